// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream: Fibonacci LFSR producing OUT_W-bit samples per cycle over a valid/ready stream
module lfsr_prng_stream #(
  parameter int N = 23,
  parameter logic [N-1:0] TAPS = 23'h420000,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     seed,
  input  logic             seed_load,
  input  logic             en,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seed_zero,
  output logic [31:0]      sample_cnt
);
  typedef enum logic {IDLE, RUN} st_t;
  st_t st, st_nxt;
  logic [N-1:0] lfsr, lfsr_nxt;
  logic [OUT_W-1:0] smp;
  logic f, gen, hs;
  // FSM register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;
  // next state, handshake/generate decisions, and the OUT_W-step unrolled sample
  always_comb begin
    st_nxt = seed_load ? RUN : st;
    hs = out_valid && out_ready;
    gen = (st == RUN) && en && !seed_load && (!out_valid || out_ready);
    lfsr_nxt = lfsr;
    smp = '0;
    f = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      f = ^(lfsr_nxt & TAPS);
      smp = (smp << 1) | OUT_W'(f);
      lfsr_nxt = {lfsr_nxt[N-2:0], f};
    end
  end
  // datapath: load wins over generation; a zero seed becomes 1 so the LFSR never locks up
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= N'(1);
      out_data <= '0;
      out_valid <= 1'b0;
      seed_zero <= 1'b0;
      sample_cnt <= '0;
    end else begin
      seed_zero <= seed_load && (seed == '0);
      if (seed_load) begin
        lfsr <= (seed == '0) ? N'(1) : seed;
        out_valid <= 1'b0;
        sample_cnt <= '0;
      end else begin
        if (gen) begin
          lfsr <= lfsr_nxt;
          out_data <= smp;
          out_valid <= 1'b1;
        end else if (hs) out_valid <= 1'b0;
        if (hs) sample_cnt <= sample_cnt + 32'd1;
      end
    end
endmodule

// File: doc/lfsr_prng_stream.md
LFSR_PRNG_STREAM -- requirements
Module: lfsr_prng_stream

Interface
REQ-001 SHALL have parameter N, default 23: LFSR state width, legal range 4..64.
REQ-002 SHALL have parameter TAPS, default 23'h420000 (bits 22,17; x^23+x^18+1): N-bit feedback tap mask, bit N-1 always set.
REQ-003 SHALL have parameter OUT_W, default 8: LFSR steps per sample and output sample width, legal range 1..N.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 seed  in  N  seed value, sampled only when seed_load=1.
REQ-007 seed_load  in  1  single-cycle request to (re)load the LFSR state from seed.
REQ-008 en  in  1  generation enable; 0 = no new samples produced.
REQ-009 out_data  out  OUT_W  random sample, registered.
REQ-010 out_valid  out  1  out_data holds an unconsumed sample.
REQ-011 out_ready  in  1  consumer accepts out_data when out_valid=1 on the same edge.
REQ-012 seed_zero  out  1  one-cycle pulse: an all-zero seed was substituted.
REQ-013 sample_cnt  out  32  count of completed handshakes since reset/last load, wraps 2^32-1 -> 0.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE (no valid seed) and RUN.
REQ-015 IDLE -> RUN on seed_load=1; RUN -> RUN on seed_load=1 (reload); no other transitions except reset.
REQ-016 One LFSR step SHALL be: f = XOR of state bits selected by TAPS; state <= {state[N-2:0], f}.
REQ-017 A sample SHALL be OUT_W consecutive steps unrolled in one cycle; first-step f in out_data[OUT_W-1], last in out_data[0].
REQ-018 In RUN with en=1 and seed_load=0, when out_valid=0 or out_ready=1: out_data <= new sample, out_valid <= 1, state advances OUT_W steps, all on that edge.
REQ-019 In RUN with out_valid=1 and out_ready=0: out_data, state and out_valid SHALL hold (no sample loss, no sample skipped).
REQ-020 In RUN with en=0: state frozen; a pending sample SHALL remain valid until consumed, then out_valid <= 0.
REQ-021 seed_load=1 SHALL load state <= seed (or 1 if seed==0), set out_valid <= 0, clear sample_cnt, move to RUN; first new out_valid at the second edge after load (latency 2).
REQ-022 seed==0 on load SHALL load state = 1 and pulse seed_zero for exactly the following cycle.
REQ-023 seed_load coincident with out_valid=1 & out_ready=1: the handshake completes (consumer keeps the sample), then the load flush applies; sample_cnt SHALL be 0 after the edge.
REQ-024 In IDLE out_valid SHALL remain 0 regardless of en/out_ready.
REQ-025 sample_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=1, except per REQ-023.
REQ-026 The LFSR state SHALL never become all-zero; an all-zero state SHALL be impossible by construction.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM=IDLE, state=1, out_data=0, out_valid=0, seed_zero=0, sample_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending sample; seed_load required before output resumes.

Verification
REQ-029 Defaults, seed=1, load, en=1, out_ready=1 -> out_valid rises 2 edges after load; samples 0x00, 0x00, 0x42 on consecutive cycles.
REQ-030 Same as REQ-029, out_ready=0 for 5 cycles after first valid -> out_data stays 0x00, out_valid=1, then 0x00, 0x42 resume with no gap/skip.
REQ-031 Load seed=0 -> seed_zero pulses 1 cycle; output sequence identical to seed=1 case.
REQ-032 After reset, en=1, out_ready=1, no seed_load for 20 cycles -> out_valid stays 0; then mid-stream rst_n low -> out_valid=0, sample_cnt=0 asynchronously.
REQ-033 seed_load during an accepting handshake -> sample_cnt=0 next cycle, out_valid=0 one cycle, then first sample of new seed.
REQ-034 N=5, TAPS=5'h14, OUT_W=1, seed=1, free run 62 samples -> sequence period 31, state never 0.
